// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin sharing of an external SR flag bank, clean S/R pulses and done/err reporting
// Ports: clk/rst (sync, active-high); req/req_op/req_idx per requester (op 01 set, 10 reset, 11 toggle, 00 no-op);
//   q_in flag feedback; s_out/r_out registered flop drives (never both high); gnt one-hot grant;
//   done one-cycle completion pulse with err; busy high outside IDLE.
// Build option: define SR_VERIFY_EN to add the CHECK state that compares q_in against the target after the pulse.
module sr_flag_arbiter #(
    parameter int NREQ      = 4,
    parameter int NFLAG     = 8,
    parameter int IDX_W     = 3,
    parameter int PULSE_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [IDX_W*NREQ-1:0] req_idx,
    input  logic [NFLAG-1:0]      q_in,
    output logic [NFLAG-1:0]      s_out,
    output logic [NFLAG-1:0]      r_out,
    output logic [NREQ-1:0]       gnt,
    output logic                  done,
    output logic                  err,
    output logic                  busy
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int CW = PULSE_CYC > 1 ? $clog2(PULSE_CYC) : 1;

    typedef enum logic [2:0] {IDLE, GRANT, DRIVE, CHECK, DONE} state_t;

    state_t           state;
    logic [PW-1:0]    ptr, win, nxt_ptr;
    logic             any;
    logic [1:0]       w_op, op;
    logic [IDX_W-1:0] w_idx, idx;
    logic [CW-1:0]    cnt;
    logic             tgt, tgt_now, bad, q_sel;
    logic [NFLAG-1:0] sel;

    // Scanning downward lets the lowest offset from ptr win, giving the round-robin order.
    always_comb begin
        win = '0;
        any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[PW'((int'(ptr) + i) % NREQ)]) begin
                win = PW'((int'(ptr) + i) % NREQ);
                any = 1'b1;
            end
        end
        w_op  = '0;
        w_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                w_op  = req_op[2*i +: 2];
                w_idx = req_idx[IDX_W*i +: IDX_W];
            end
        end
    end

    assign nxt_ptr = PW'((int'(win) + 1) % NREQ);
    // An out-of-range index shifts the one-hot out entirely, so sel is all zero for it.
    assign sel     = NFLAG'(1) << idx;
    assign bad     = int'(idx) >= NFLAG;
    assign q_sel   = |(q_in & sel);
    assign tgt_now = op[1] ? (op[0] & ~q_sel) : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s_out <= '0;
            r_out <= '0;
            gnt   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            ptr   <= '0;
            op    <= '0;
            idx   <= '0;
            cnt   <= '0;
            tgt   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        state <= GRANT;
                        gnt   <= NREQ'(1) << win;
                        busy  <= 1'b1;
                        ptr   <= nxt_ptr;
                        op    <= w_op;
                        idx   <= w_idx;
                    end
                end
                GRANT: begin
                    tgt <= tgt_now;
                    cnt <= '0;
                    if (op == 2'b00 || bad) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= bad;
                    end else begin
                        state <= DRIVE;
                        s_out <= tgt_now ? sel : '0;
                        r_out <= tgt_now ? '0 : sel;
                    end
                end
                DRIVE: begin
                    if (cnt == CW'(PULSE_CYC - 1)) begin
                        s_out <= '0;
                        r_out <= '0;
`ifdef SR_VERIFY_EN
                        state <= CHECK;
`else
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CHECK: begin
                    state <= DONE;
                    done  <= 1'b1;
                    err   <= q_sel != tgt;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb_sr_flag_arbiter: randomized scoreboard bench for sr_flag_arbiter driving a behavioural SR flag bank
module tb_sr_flag_arbiter;
    localparam int NREQ  = 4;
    localparam int NFLAG = 6;
    localparam int IDX_W = 3;
    localparam int P     = 2;
`ifdef SR_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [7:0]  req_op = '0;
    logic [11:0] req_idx = '0;
    logic [5:0]  q = '0;
    logic [5:0]  hold = '0;
    logic [5:0]  s_out, r_out;
    logic [3:0]  gnt;
    logic        done, err, busy;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;

    typedef struct {
        logic [3:0] gnt;
        logic       err;
        int         lat;
        int         pulses;
        logic [5:0] smask;
        logic [5:0] rmask;
        logic [5:0] flags;
    } exp_t;

    exp_t       exp_q[$];
    logic [5:0] mflags = '0;
    int         mptr = 0;

    sr_flag_arbiter #(
        .NREQ(NREQ), .NFLAG(NFLAG), .IDX_W(IDX_W), .PULSE_CYC(P)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_idx(req_idx), .q_in(q),
        .s_out(s_out), .r_out(r_out), .gnt(gnt), .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // External SR flag bank; a held bit is pinned low to emulate a stuck flop.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) q <= ((q | s_out) & ~r_out) & ~hold;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: serve all pending requests in round-robin order, applying each op to the flag array.
    task automatic predict(input logic [3:0] m, input logic [7:0] ops, input logic [11:0] idxs);
        logic [3:0] pend;
        exp_t       e;
        int         w;
        logic [1:0] o;
        int         x;
        logic       t;
        pend = m;
        while (pend != 0) begin
            w = mptr;
            while (!pend[w]) w = (w + 1) % NREQ;
            pend[w] = 1'b0;
            mptr    = (w + 1) % NREQ;
            o       = ops[2*w +: 2];
            x       = int'(idxs[3*w +: 3]);
            e.gnt    = 4'b0001 << w;
            e.err    = x >= NFLAG;
            e.smask  = '0;
            e.rmask  = '0;
            e.pulses = 0;
            e.lat    = 1;
            if (o != 2'b00 && x < NFLAG) begin
                t = (o == 2'b01) ? 1'b1 : (o == 2'b10) ? 1'b0 : !mflags[x];
                if (t) e.smask[x] = 1'b1;
                else   e.rmask[x] = 1'b1;
                e.pulses  = P;
                e.lat     = P + 1 + VER;
                mflags[x] = hold[x] ? 1'b0 : t;
                if (VER == 1 && mflags[x] != t) e.err = 1'b1;
            end
            e.flags = mflags;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_batch(input logic [3:0] m, input logic [7:0] ops, input logic [11:0] idxs);
        int left;
        int budget;
        left   = $countones(m);
        budget = 200;
        predict(m, ops, idxs);
        req_op  = ops;
        req_idx = idxs;
        req     = m;
        @(negedge clk);
        check("grant_start", gnt != 0, 1);
        while (left > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (done) begin
                req = req & ~gnt;
                left--;
            end
        end
        if (left > 0) check("batch_timeout", left, 0);
        @(negedge clk);
    endtask

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t       e;
        logic [3:0] prev_gnt;
        int         start;
        int         pc;
        logic [5:0] so, ro;
        prev_gnt = '0;
        start    = 0;
        pc       = 0;
        so       = '0;
        ro       = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("s_and_r", 32'(s_out & r_out), 0);
                check("busy_vs_gnt", busy, gnt != 0);
                if (gnt != 0 && prev_gnt == 0) begin
                    start = cyc;
                    pc    = 0;
                    so    = '0;
                    ro    = '0;
                end
                if ((s_out | r_out) != 0) begin
                    pc++;
                    so = so | s_out;
                    ro = ro | r_out;
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("gnt", gnt, e.gnt);
                        check("err", err, e.err);
                        check("latency", cyc - start, e.lat);
                        check("pulse_cycles", pc, e.pulses);
                        check("s_mask", so, e.smask);
                        check("r_mask", ro, e.rmask);
                        check("flags", q, e.flags);
                    end
                end
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        repeat (2) @(negedge clk);
        check("rst_s", s_out, 0);
        check("rst_r", r_out, 0);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_gnt", gnt, 0);

        run_batch(4'b1111, 8'h00, 12'h000);
        run_batch(4'b1111, 8'hFF, 12'h000);
        run_batch(4'b0001, 8'h03, 12'h000);
        run_batch(4'b0010, 8'h04, 12'h028);
        run_batch(4'b0100, 8'h10, 12'h1C0);
        run_batch(4'b0100, 8'h00, 12'h040);
        hold = 6'b001000;
        run_batch(4'b0001, 8'h01, 12'h003);
        hold = '0;

        req_op  = 8'h04;
        req_idx = 12'h010;
        req     = 4'b0010;
        b = 0;
        while ((s_out | r_out) == 0 && b < 20) begin
            @(negedge clk);
            b++;
        end
        check("drive_seen", (s_out | r_out) != 0, 1);
        rst = 1'b1;
        req = '0;
        exp_q.delete();
        @(negedge clk);
        check("abort_s", s_out, 0);
        check("abort_r", r_out, 0);
        check("abort_gnt", gnt, 0);
        check("abort_done", done, 0);
        rst  = 1'b0;
        mptr = 0;
        @(negedge clk);
        check("abort_quiet", done, 0);
        run_batch(4'b1111, 8'h00, 12'h000);

        for (int n = 0; n < 40; n++) begin
            logic [3:0]  m;
            logic [7:0]  o;
            logic [11:0] x;
            m = 4'($urandom_range(1, 15));
            o = 8'($urandom);
            x = 12'($urandom);
            run_batch(m, o, x);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
